addr_data_latch_unit: RTL

- Downstream consumer of the bus-control stage.
- Holds the external address bus registers (ABL/ABH), the data input latch (DL) and the data output register (DOR).
- Generates the R/W pin state and applies the ready stall.
- Turns bus-control strobes (ADL_ABL, ADH_ABH, DL_DB, DL_ADL, DL_ADH) into register loads and internal-bus drive enables, from one master clock split internally into PHI1/PHI2 halves.

---
 rtl/core6502_bus_pkg.sv | 13 +
 rtl/addr_data_latch_unit_phase_gen.sv | 27 ++
 rtl/addr_data_latch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/core6502_bus_pkg.sv
// Shared bus-stage constants: phase encoding, reset values, bus width.
package core6502_bus_pkg;

    localparam int BUS_W = 8;

    // Phase flop encoding: 0 while in PHI1, 1 while in PHI2
    localparam logic PH_PHI1 = 1'b0;
    localparam logic PH_PHI2 = 1'b1;

    localparam logic [2*BUS_W-1:0] AB_RESET_DEF = 16'h0000;
    localparam logic [BUS_W-1:0]   DL_RESET_DEF = 8'h00;

endpackage

// File: rtl/addr_data_latch_unit_phase_gen.sv
// Two-phase generator: one flop toggled by every PHI0 rising edge.
// PHI1/PHI2 come straight from that flop, so they cannot glitch.
module phase_gen
    import core6502_bus_pkg::*;
(
    input  logic PHI0,
    input  logic n_RES,
    output logic PHI1,
    output logic PHI2,
    output logic end_phi1,   // the coming PHI0 edge closes a PHI1 half
    output logic end_phi2    // the coming PHI0 edge closes a PHI2 half
);

    logic phase;

    // Phase toggles on every master edge; reset parks it in PHI1
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) phase <= PH_PHI1;
        else        phase <= ~phase;
    end

    assign PHI1     = (phase == PH_PHI1);
    assign PHI2     = (phase == PH_PHI2);
    assign end_phi1 = (phase == PH_PHI1);
    assign end_phi2 = (phase == PH_PHI2);

endmodule

// File: rtl/addr_data_latch_unit.sv
// Address bus registers, data latch, data output register and R/W pin.
// Bus-control strobes become register loads at the end of PHI1 and
// DL drive enables during PHI1; the read path latches at the end of PHI2.
module addr_data_latch_unit
    import core6502_bus_pkg::*;
#(
    parameter logic [2*BUS_W-1:0] AB_RESET = AB_RESET_DEF,
    parameter logic [BUS_W-1:0]   DL_RESET = DL_RESET_DEF
) (
    input  logic               PHI0,
    input  logic               n_RES,
    output logic               PHI1,
    output logic               PHI2,
    input  logic               ADL_ABL,
    input  logic               ADH_ABH,
    input  logic               DL_DB,
    input  logic               DL_ADL,
    input  logic               DL_ADH,
    input  logic               WR,
    input  logic               n_ready,
    input  logic [BUS_W-1:0]   ADL,
    input  logic [BUS_W-1:0]   ADH,
    input  logic [BUS_W-1:0]   DB,
    input  logic [BUS_W-1:0]   D_in,
    output logic [BUS_W-1:0]   D_out,
    output logic               D_oe,
    output logic [2*BUS_W-1:0] A,
    output logic               RnW,
    output logic [BUS_W-1:0]   DB_drv,
    output logic [BUS_W-1:0]   ADL_drv,
    output logic [BUS_W-1:0]   ADH_drv,
    output logic               DB_en,
    output logic               ADL_en,
    output logic               ADH_en
);

    logic             end_phi1, end_phi2;
    logic             stall;
    logic [BUS_W-1:0] abl_q, abh_q, dl_q, dor_q;
    logic             rnw_q;

    phase_gen u_phase (
        .PHI0     (PHI0),
        .n_RES    (n_RES),
        .PHI1     (PHI1),
        .PHI2     (PHI2),
        .end_phi1 (end_phi1),
        .end_phi2 (end_phi2)
    );

    // RDY only freezes reads; a write cycle always completes
    assign stall = n_ready & rnw_q;

    // Address halves, DOR and R/W advance at end of PHI1 unless stalled
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            abl_q <= AB_RESET[BUS_W-1:0];
            abh_q <= AB_RESET[2*BUS_W-1:BUS_W];
            dor_q <= '0;
            rnw_q <= 1'b1;
        end else if (end_phi1 && !stall) begin
            if (ADL_ABL) abl_q <= ADL;
            if (ADH_ABH) abh_q <= ADH;
            dor_q <= DB;
            rnw_q <= ~WR;
        end
    end

    // Data latch samples the pins at end of PHI2 on every read cycle
    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES)                  dl_q <= DL_RESET;
        else if (end_phi2 && rnw_q)  dl_q <= D_in;
    end

    assign A       = {abh_q, abl_q};
    assign RnW     = rnw_q;
    assign D_out   = dor_q;
    assign D_oe    = ~rnw_q & PHI2;

    // DL is offered to all three internal buses; enables gate it to PHI1
    assign DB_drv  = dl_q;
    assign ADL_drv = dl_q;
    assign ADH_drv = dl_q;
    assign DB_en   = DL_DB  & PHI1;
    assign ADL_en  = DL_ADL & PHI1;
    assign ADH_en  = DL_ADH & PHI1;

endmodule
